// File: rtl/bus_term_pkg.sv
// Shared definitions for the bus terminal port.
//   ID_W          : width of the destination-ID field at the top of a packet
//   BCAST_DEFAULT : default broadcast destination ID
//   PKT_MAX       : widest packet get_dest() accepts (callers zero-extend)
//   get_dest()    : extracts the destination ID from a packet of width w
package bus_term_pkg;

  localparam int unsigned ID_W    = 8;
  localparam int unsigned PKT_MAX = 256;
  localparam logic [ID_W-1:0] BCAST_DEFAULT = '1;

  function automatic logic [ID_W-1:0] get_dest(input logic [PKT_MAX-1:0] pkt,
                                               input int unsigned w);
    logic [PKT_MAX-1:0] sh;
    sh = pkt >> (w - ID_W);
    return sh[ID_W-1:0];
  endfunction

endpackage

// File: rtl/term_fifo.sv
// Synchronous FIFO with wrapping pointers and a separate occupancy count.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
// A pop on an empty FIFO is ignored.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   push, din  : enqueue request and data
//   pop        : dequeue request
//   full/empty : occupancy flags
//   head       : oldest entry, or zero when empty
module term_fifo #(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [width-1:0] head
);

  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_eff, pop_eff;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(depth));
  assign pop_eff  = pop && !empty;
  assign push_eff = push && (!full || pop_eff);
  // Forced to zero when empty so the head reads 0 straight out of reset
  // without the storage array needing a reset.
  assign head     = empty ? '0 : mem[rd_q];

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (pop_eff)  rd_d = rd_q + 1'b1;
    if (push_eff) wr_d = wr_q + 1'b1;
    case ({push_eff, pop_eff})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_q] <= din;
  end

endmodule

// File: rtl/bus_term_port.sv
// Bus terminal port: a TX FIFO from the user toward the bus and an RX FIFO
// from the bus toward the user. The bus has no backpressure on delivery;
// RX packets arriving while the RX FIFO is full are dropped and flagged in
// the sticky rx_ovf output.
// Optional feature (macro BUS_TERM_ID_CHECK_EN): delivered packets whose
// destination is neither id nor broadcast are discarded and counted in the
// 8-bit saturating output misroute_cnt.
// Ports:
//   clk, reset               : clock, asynchronous active-high reset
//   pndng, pop, D_pop        : bus side of the TX FIFO
//   push, D_push             : bus side of the RX FIFO
//   tx_wr, tx_data, tx_full  : user write side
//   rx_rd, rx_data, rx_valid : user read side
//   rx_ovf                   : sticky RX drop flag
//   misroute_cnt             : misrouted packet count (macro builds only)
module bus_term_port
  import bus_term_pkg::*;
#(
  parameter int unsigned     pckg_sz   = 16,
  parameter int unsigned     depth     = 8,
  parameter logic [ID_W-1:0] id        = 8'd0,
  parameter logic [ID_W-1:0] broadcast = BCAST_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  input  logic               pop,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_valid,
`ifdef BUS_TERM_ID_CHECK_EN
  output logic [7:0]         misroute_cnt,
`endif
  output logic               rx_ovf
);

  logic tx_empty, rx_full, rx_empty;
  logic dest_ok, rx_push;
  logic ovf_q, ovf_d;

`ifdef BUS_TERM_ID_CHECK_EN
  logic [ID_W-1:0] dest;
  logic [7:0]      mis_q, mis_d;

  assign dest    = get_dest(PKT_MAX'(D_push), pckg_sz);
  assign dest_ok = (dest == id) || (dest == broadcast);

  always_comb begin
    mis_d = mis_q;
    if (push && !dest_ok && (mis_q != '1)) mis_d = mis_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mis_q <= '0;
    else       mis_q <= mis_d;
  end

  assign misroute_cnt = mis_q;
`else
  assign dest_ok = 1'b1;
`endif

  assign rx_push = push && dest_ok;

  term_fifo #(.width(pckg_sz), .depth(depth)) u_tx (
    .clk   (clk),
    .reset (reset),
    .push  (tx_wr),
    .din   (tx_data),
    .pop   (pop),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (D_pop)
  );

  term_fifo #(.width(pckg_sz), .depth(depth)) u_rx (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .din   (D_push),
    .pop   (rx_rd),
    .full  (rx_full),
    .empty (rx_empty),
    .head  (rx_data)
  );

  assign pndng    = !tx_empty;
  assign rx_valid = !rx_empty;

  // A drop happens only when the FIFO is full and no read frees a slot in
  // the same cycle; rx_rd on a full FIFO always dequeues, so it suffices.
  always_comb begin
    ovf_d = ovf_q;
    if (rx_push && rx_full && !rx_rd) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 1'b0;
    else       ovf_q <= ovf_d;
  end

  assign rx_ovf = ovf_q;

endmodule

// File: tb/tb_bus_term_port.sv
module tb_bus_term_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng, pop, push, tx_wr, tx_full, rx_rd, rx_valid, rx_ovf;
  logic [15:0] D_pop, D_push, tx_data, rx_data;
`ifdef BUS_TERM_ID_CHECK_EN
  logic [7:0]  misroute_cnt;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  bus_term_port #(.pckg_sz(16), .depth(8), .id(8'd2)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .pop      (pop),
    .D_pop    (D_pop),
    .push     (push),
    .D_push   (D_push),
    .tx_wr    (tx_wr),
    .tx_data  (tx_data),
    .tx_full  (tx_full),
    .rx_rd    (rx_rd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
`ifdef BUS_TERM_ID_CHECK_EN
    .misroute_cnt (misroute_cnt),
`endif
    .rx_ovf   (rx_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        tx_wr;
    logic [15:0] tx_data;
    logic        pop;
    logic        push;
    logic [15:0] d_push;
    logic        rx_rd;
    logic        e_pndng;
    logic [15:0] e_dpop;
    logic        e_full;
    logic        e_rxv;
    logic [15:0] e_rxd;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(logic w, logic [15:0] wd, logic p, logic ps,
                              logic [15:0] pd, logic r, logic ep,
                              logic [15:0] edp, logic ef, logic erv,
                              logic [15:0] erd);
    vec_t v;
    v.tx_wr = w; v.tx_data = wd; v.pop = p; v.push = ps; v.d_push = pd;
    v.rx_rd = r; v.e_pndng = ep; v.e_dpop = edp; v.e_full = ef;
    v.e_rxv = erv; v.e_rxd = erd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    tx_wr = 0; pop = 0; push = 0; rx_rd = 0;
  endtask

  // Drive settles before the edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    tx_data = '0; D_push = '0;
    reset = 1'b1;
    #12;
    check("rst_pndng", 32'(pndng), 0);
    check("rst_full",  32'(tx_full), 0);
    check("rst_rxv",   32'(rx_valid), 0);
    check("rst_ovf",   32'(rx_ovf), 0);
    check("rst_dpop",  32'(D_pop), 0);
    check("rst_rxd",   32'(rx_data), 0);
    @(negedge clk);
    reset = 1'b0;

    //             wr  wdata     pop ps  pdata     rd   pnd  dpop      full rxv  rxd
    vecs[0]  = mk(1, 16'h0111, 0, 0, 16'h0000, 0,   1, 16'h0111, 0, 0, 16'h0000);
    vecs[1]  = mk(1, 16'h0222, 0, 0, 16'h0000, 0,   1, 16'h0111, 0, 0, 16'h0000);
    vecs[2]  = mk(0, 16'h0000, 1, 0, 16'h0000, 0,   1, 16'h0222, 0, 0, 16'h0000);
    vecs[3]  = mk(0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 16'h0000);
    vecs[4]  = mk(0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 16'h0000);
    vecs[5]  = mk(0, 16'h0000, 0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 16'h0000);
    vecs[6]  = mk(0, 16'h0000, 0, 1, 16'h0AAA, 0,   0, 16'h0000, 0, 1, 16'h0AAA);
    vecs[7]  = mk(0, 16'h0000, 1, 1, 16'h0BBB, 0,   0, 16'h0000, 0, 1, 16'h0AAA);
    vecs[8]  = mk(0, 16'h0000, 0, 0, 16'h0000, 1,   0, 16'h0000, 0, 1, 16'h0BBB);
    vecs[9]  = mk(0, 16'h0000, 0, 1, 16'h0CCC, 1,   0, 16'h0000, 0, 1, 16'h0CCC);
    vecs[10] = mk(0, 16'h0000, 0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 16'h0000);
    vecs[11] = mk(0, 16'h0000, 0, 0, 16'h0000, 1,   0, 16'h0000, 0, 0, 16'h0000);
    vecs[12] = mk(1, 16'h0333, 0, 0, 16'h0000, 0,   1, 16'h0333, 0, 0, 16'h0000);
    vecs[13] = mk(0, 16'h0000, 1, 0, 16'h0000, 0,   0, 16'h0000, 0, 0, 16'h0000);

    for (int i = 0; i < 14; i++) begin
      tx_wr = vecs[i].tx_wr; tx_data = vecs[i].tx_data; pop = vecs[i].pop;
      push = vecs[i].push; D_push = vecs[i].d_push; rx_rd = vecs[i].rx_rd;
      step();
      check($sformatf("v%0d_pndng", i), 32'(pndng),   32'(vecs[i].e_pndng));
      check($sformatf("v%0d_dpop", i),  32'(D_pop),   32'(vecs[i].e_dpop));
      check($sformatf("v%0d_full", i),  32'(tx_full), 32'(vecs[i].e_full));
      check($sformatf("v%0d_rxv", i),   32'(rx_valid), 32'(vecs[i].e_rxv));
      check($sformatf("v%0d_rxd", i),   32'(rx_data), 32'(vecs[i].e_rxd));
    end
    idle();

    // TX full: 8 writes, 9th alone dropped, write+pop on full accepted.
    for (int i = 0; i < 8; i++) begin
      tx_wr = 1; tx_data = 16'h1000 + 16'(i);
      step();
      check($sformatf("txf_full%0d", i), 32'(tx_full), (i == 7) ? 1 : 0);
    end
    tx_data = 16'h1FFF;
    step();
    check("txf_drop_full", 32'(tx_full), 1);
    check("txf_drop_head", 32'(D_pop), 32'h1000);
    tx_data = 16'h2000; pop = 1;
    step();
    check("txf_wp_full", 32'(tx_full), 1);
    check("txf_wp_head", 32'(D_pop), 32'h1001);
    tx_wr = 0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("txf_order%0d", i), 32'(D_pop),
            (i == 7) ? 32'h2000 : 32'h1001 + 32'(i));
      step();
    end
    check("txf_empty", 32'(pndng), 0);
    idle();

    // RX overflow: 9 pushes with no reads.
    for (int i = 0; i < 9; i++) begin
      push = 1; D_push = 16'h3000 + 16'(i);
      step();
      check($sformatf("rxo_ovf%0d", i), 32'(rx_ovf), (i == 8) ? 1 : 0);
    end
    push = 0;
    check("rxo_valid", 32'(rx_valid), 1);
    rx_rd = 1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rxo_order%0d", i), 32'(rx_data), 32'h3000 + 32'(i));
      step();
    end
    check("rxo_empty", 32'(rx_valid), 0);
    check("rxo_sticky", 32'(rx_ovf), 1);
    idle();

    // Destination filtering (id = 2).
    push = 1;
    D_push = 16'h0255; step();
    D_push = 16'hFF55; step();
    D_push = 16'h0355; step();
    push = 0;
    check("id_head0", 32'(rx_data), 32'h0255);
    rx_rd = 1; step();
    check("id_head1", 32'(rx_data), 32'hFF55);
    step();
`ifdef BUS_TERM_ID_CHECK_EN
    check("id_drop", 32'(rx_valid), 0);
    check("id_miscnt", 32'(misroute_cnt), 1);
`else
    check("id_head2", 32'(rx_data), 32'h0355);
    step();
    check("id_empty", 32'(rx_valid), 0);
`endif
    check("id_ovf_sticky", 32'(rx_ovf), 1);
    idle();

    // Reset mid-operation: 3 TX, 2 RX entries, reset between edges.
    tx_wr = 1; push = 1;
    tx_data = 16'h4001; D_push = 16'h5001; step();
    tx_data = 16'h4002; D_push = 16'h5002; step();
    push = 0;
    tx_data = 16'h4003; step();
    check("mid_pre_pndng", 32'(pndng), 1);
    check("mid_pre_rxv", 32'(rx_valid), 1);
    tx_data = 16'h4444;
    #2;
    reset = 1'b1;
    #1;
    check("mid_pndng", 32'(pndng), 0);
    check("mid_rxv",   32'(rx_valid), 0);
    check("mid_dpop",  32'(D_pop), 0);
    check("mid_rxd",   32'(rx_data), 0);
    check("mid_ovf",   32'(rx_ovf), 0);
    check("mid_full",  32'(tx_full), 0);
    step();
    check("mid_hold_pndng", 32'(pndng), 0);
    @(negedge clk);
    reset = 1'b0;
    tx_wr = 0;
    step();
    check("mid_after_pndng", 32'(pndng), 0);
    tx_wr = 1; tx_data = 16'h4555;
    step();
    check("mid_resume_head", 32'(D_pop), 32'h4555);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_term_port.md
BUS_TERM_PORT -- requirements
Module: bus_term_port

Interface
REQ-001 SHALL have parameter pckg_sz, default 16, packet width in bits; top 8 bits are the destination ID.
REQ-002 SHALL have parameter depth, default 8, entries per FIFO (power of two, >=2).
REQ-003 SHALL have parameter id, default 0, this terminal's 8-bit ID.
REQ-004 SHALL have parameter broadcast, default {8{1'b1}}, broadcast destination ID.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port pndng  output  1  TX FIFO non-empty, toward bus.
REQ-008 SHALL have port pop  input  1  bus consumes TX head this cycle.
REQ-009 SHALL have port D_pop  output  pckg_sz  TX FIFO head.
REQ-010 SHALL have port push  input  1  bus delivers a packet this cycle.
REQ-011 SHALL have port D_push  input  pckg_sz  delivered packet.
REQ-012 SHALL have port tx_wr / tx_data / tx_full  input 1 / input pckg_sz / output 1  user TX write side.
REQ-013 SHALL have port rx_rd / rx_data / rx_valid  input 1 / output pckg_sz / output 1  user RX read side.
REQ-014 SHALL have port rx_ovf  output  1  sticky flag, an RX packet was dropped because the RX FIFO was full.

Function
REQ-015 SHALL implement the TX path as a depth-entry FIFO: tx_wr with !tx_full enqueues tx_data at the edge.
REQ-016 SHALL drive pndng = (TX count != 0) and D_pop = TX head combinationally from registered storage, with zero extra latency.
REQ-017 SHALL dequeue the TX head at the edge on which pop && pndng; pop while !pndng is ignored with no state change.
REQ-018 SHALL, when tx_wr and pop coincide on a full TX FIFO, accept both; the count stays at depth.
REQ-019 SHALL ignore tx_wr while tx_full and no pop occurs.
REQ-020 SHALL implement the RX path as a depth-entry FIFO: push enqueues D_push; the bus has no backpressure.
REQ-021 SHALL, on push while RX is full and rx_rd is not asserted, drop D_push and set rx_ovf; push with rx_rd on a full FIFO is accepted.
REQ-022 SHALL drive rx_valid = (RX count != 0) and rx_data = RX head; rx_rd with rx_valid dequeues at the edge; rx_rd while !rx_valid is ignored.
REQ-023 SHALL use wrapping read and write pointers of log2(depth) bits with a separate count of log2(depth)+1 bits.
REQ-024 SHALL clear rx_ovf only by reset.

Reset
REQ-025 SHALL, on reset assertion, immediately clear both FIFOs and flags: pndng=0, tx_full=0, rx_valid=0, rx_ovf=0, D_pop=0, rx_data=0.
REQ-026 SHALL discard any in-flight pop/push/tx_wr/rx_rd sampled while reset is high, and SHALL resume on the first edge after deassertion.

Configuration
REQ-027 SHALL support macro BUS_TERM_ID_CHECK_EN: when defined, a pushed packet whose D_push[pckg_sz-1 -:8] is neither id nor broadcast is not enqueued and increments an 8-bit saturating output misroute_cnt (reset 0).
REQ-028 SHALL, without BUS_TERM_ID_CHECK_EN, enqueue every push regardless of destination and omit misroute_cnt.

Structure
REQ-029 SHALL place the ID field width (8), the default broadcast constant, and a get_dest(pkt) function in shared package bus_term_pkg.
REQ-030 SHALL instantiate sub-module term_fifo (parameters width and depth; push/pop/full/empty/head) twice, once for TX and once for RX.

Verification
REQ-031 SHALL verify TX ordering: write 16'h0111, 16'h0222 -> pndng=1 with D_pop=16'h0111; pop -> D_pop=16'h0222; pop -> pndng=0.
REQ-032 SHALL verify TX full: 8 writes -> tx_full=1; 9th write alone is dropped; write+pop together -> count 8, order preserved.
REQ-033 SHALL verify RX overflow: 9 pushes without rx_rd -> rx_valid=1, 8 entries read back in order, 9th lost, rx_ovf=1 until reset.
REQ-034 SHALL verify ID check (id=2, macro on): push 16'h0255 stored, 16'hFF55 stored, 16'h0355 dropped -> misroute_cnt=1.
REQ-035 SHALL verify reset mid-operation: reset asserted with 3 TX and 2 RX entries -> pndng=0, rx_valid=0 immediately, without waiting for a clock edge.
REQ-036 SHALL verify empty pops: pop with pndng=0 and rx_rd with rx_valid=0 -> no state change and no pointer wrap.
